bip_uart_dbg: RTL and testbench
===============================

// Module: bip_uart_dbg
// PURPOSE
//  Command-driven debug controller between the UART FIFOs and a BIP core; successor to the fixed-width BIP/UART interface.
//  Decodes single-byte host commands (reset, step, run, read ACC/PC/cycle count) and gates BIP execution via a clock enable.
//  Returns register values as LSB-first byte streams of parametrised width.
//  Sits at the system top between uart and BIP2; the top ORs bip_reset with the global reset.
// PARAMETERS
//  ACC_W    16       BIP accumulator width (1..64)
//  PC_W     11       BIP program counter width (1..32)
//  CNT_W    32       executed-cycle counter width (8..64)
//  RST_CYC  4        cycles bip_reset is held high per 'R' command (>=1)
//  RUN_MAX  1000000  max enabled cycles per 'G' before timeout (>=1)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  rx_empty   in   1      uart RX FIFO empty
//  r_data     in   8      RX FIFO head byte, show-ahead, valid while rx_empty=0
//  rd_uart    out  1      pop RX FIFO (1-cycle pulse)
//  tx_full    in   1      uart TX FIFO full
//  w_data     out  8      byte to TX FIFO
//  wr_uart    out  1      push w_data (1-cycle pulse)
//  bip_acc    in   ACC_W  BIP accumulator
//  bip_pc     in   PC_W   BIP program counter
//  bip_halt   in   1      BIP decoded halt instruction (level)
//  bip_en     out  1      BIP clock enable; BIP advances one instruction per high cycle
//  bip_reset  out  1      BIP reset request
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cycle counter 0, shift register and byte count cleared.
//  NB(W) = (W+7)/8. Shift register width = 8*max(NB(ACC_W),NB(PC_W),NB(CNT_W)).
//  Codes: ACK=0x06, NAK=0x15, ABORT=0x18, TIMEOUT=0x14.
//  IDLE: if rx_empty=0 -> rd_uart=1 same cycle, latch r_data into cmd -> DECODE.
//  DECODE (1 cycle), by cmd:
//   0x52 'R' -> RST; 0x53 'S' -> STEP; 0x47 'G' -> RUN (run counter cleared)
//   0x41 'A' -> load zero-extended bip_acc, NB(ACC_W) bytes -> SEND
//   0x50 'P' -> load bip_pc, NB(PC_W) bytes -> SEND
//   0x43 'C' -> load cycle counter, NB(CNT_W) bytes -> SEND
//   other -> load NAK, 1 byte -> SEND
//  RST: bip_reset=1 for exactly RST_CYC cycles; cycle counter cleared; then load ACK -> SEND.
//  STEP: if bip_halt=1 -> load NAK, no enable; else bip_en=1 for exactly 1 cycle, then load ACK. -> SEND.
//  RUN, each cycle, priority order:
//   1) bip_halt=1 -> bip_en=0, load ACK
//   2) rx_empty=0 -> pop byte; 0x1B: bip_en=0, load ABORT; any other byte is discarded and the run continues
//   3) run counter = RUN_MAX -> load TIMEOUT
//   4) otherwise bip_en=1, run counter++
//   Terminations 1-3 each -> SEND 1 byte. Exactly RUN_MAX enable cycles occur before TIMEOUT.
//  SEND: per cycle with tx_full=0 -> wr_uart=1, w_data=shift[7:0], shift>>=8, count--.
//   tx_full=1 -> wr_uart=0, hold. count reaching 0 -> IDLE.
//  Cycle counter: +1 on every bip_en=1 cycle; saturates at all-ones (no wrap); cleared by reset and by RST.
//  bip_en is never high in IDLE/DECODE/RST/SEND; rd_uart is high only in IDLE or RUN.
//  Values are sampled in DECODE, so a read command returns a coherent snapshot.
//  Reset mid-operation: abandons any command and partial response. Bytes already pushed stay in the TX FIFO.
// TESTING
//  1. 'R' with RST_CYC=4 -> bip_reset high exactly 4 cycles, then TX 0x06; following 'C' -> 00 00 00 00.
//  2. BIP ACC=0x1234, ACC_W=16; 'A' -> TX 0x34 then 0x12; PC=0x5A3, 'P' -> 0xA3 0x05.
//  3. Three 'S' cmds -> three 1-cycle bip_en pulses, three 0x06; 'C' -> 03 00 00 00.
//  4. 'G', bip_halt rises after 10 enables -> TX 0x06, 'C' = 10; 'G'/'S' while halted -> 0x06/0x15, no enable.
//  5. 'G' with RUN_MAX=8, no halt -> exactly 8 enables, TX 0x14; 'G' then host 0x41,0x1B -> 0x41 dropped, TX 0x18.
//  6. tx_full held high 20 cycles during 'C' reply -> no wr_uart, bytes resume in order; 0x7F -> 0x15; reset mid-RUN -> bip_en=0 next cycle, IDLE.

Source files
------------

// File: rtl/bip_uart_dbg.sv
// bip_uart_dbg: single-byte host command decoder that resets, steps and runs a BIP core
// and streams its registers back LSB-first over the UART FIFOs.
module bip_uart_dbg #(
  parameter int ACC_W   = 16,
  parameter int PC_W    = 11,
  parameter int CNT_W   = 32,
  parameter int RST_CYC = 4,
  parameter int RUN_MAX = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [7:0]       w_data,
  output logic             wr_uart,
  input  logic [ACC_W-1:0] bip_acc,
  input  logic [PC_W-1:0]  bip_pc,
  input  logic             bip_halt,
  output logic             bip_en,
  output logic             bip_reset
);
  localparam int NBA = (ACC_W + 7) / 8;
  localparam int NBP = (PC_W + 7) / 8;
  localparam int NBC = (CNT_W + 7) / 8;
  localparam int NBM = NBA > NBP ? (NBA > NBC ? NBA : NBC) : (NBP > NBC ? NBP : NBC);
  localparam int SW  = 8 * NBM;
  localparam int RW  = $clog2(RUN_MAX + 1);
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam logic [7:0] ACK = 8'h06, NAK = 8'h15, ABORT = 8'h18, TMO = 8'h14;
  typedef enum logic [2:0] {IDLE, DECODE, RST, STEP, RUN, SEND} state_t;
  state_t           r_state;
  logic [7:0]       r_cmd;
  logic [SW-1:0]    r_shift;
  logic [3:0]       r_nb;
  logic [CNT_W-1:0] r_cyc;
  logic [RW-1:0]    r_run;
  logic [RCW-1:0]   r_rc;
  logic             w_run_en;
  // Handshakes are combinational so a show-ahead byte is popped in the cycle it is consumed.
  assign w_run_en  = r_state == RUN && !bip_halt && rx_empty && r_run != RW'(RUN_MAX);
  assign bip_en    = !reset && (r_state == STEP ? !bip_halt : w_run_en);
  assign bip_reset = !reset && r_state == RST;
  assign rd_uart   = !reset && !rx_empty && (r_state == IDLE || (r_state == RUN && !bip_halt));
  assign wr_uart   = !reset && r_state == SEND && !tx_full;
  assign w_data    = r_shift[7:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_shift <= '0;
      r_nb    <= '0;
      r_cyc   <= '0;
      r_run   <= '0;
      r_rc    <= '0;
    end else begin
      if (bip_en && !(&r_cyc)) r_cyc <= r_cyc + CNT_W'(1);
      case (r_state)
        IDLE: if (!rx_empty) begin
          r_cmd   <= r_data;
          r_state <= DECODE;
        end
        DECODE: begin
          r_state <= SEND;
          r_nb    <= 4'd1;
          r_shift <= SW'(NAK);
          case (r_cmd)
            8'h52: begin r_state <= RST; r_rc <= '0; end
            8'h53: r_state <= STEP;
            8'h47: begin r_state <= RUN; r_run <= '0; end
            8'h41: begin r_shift <= SW'(bip_acc); r_nb <= 4'(NBA); end
            8'h50: begin r_shift <= SW'(bip_pc); r_nb <= 4'(NBP); end
            8'h43: begin r_shift <= SW'(r_cyc); r_nb <= 4'(NBC); end
            default: ;
          endcase
        end
        RST: begin
          r_cyc <= '0;
          r_rc  <= r_rc + RCW'(1);
          if (r_rc == RCW'(RST_CYC - 1)) begin
            r_shift <= SW'(ACK);
            r_nb    <= 4'd1;
            r_state <= SEND;
          end
        end
        STEP: begin
          r_shift <= SW'(bip_halt ? NAK : ACK);
          r_nb    <= 4'd1;
          r_state <= SEND;
        end
        RUN: begin
          r_nb <= 4'd1;
          if (bip_halt) begin
            r_shift <= SW'(ACK);
            r_state <= SEND;
          end else if (!rx_empty) begin
            if (r_data == 8'h1B) begin
              r_shift <= SW'(ABORT);
              r_state <= SEND;
            end
          end else if (r_run == RW'(RUN_MAX)) begin
            r_shift <= SW'(TMO);
            r_state <= SEND;
          end else r_run <= r_run + RW'(1);
        end
        SEND: if (!tx_full) begin
          r_shift <= r_shift >> 8;
          r_nb    <= r_nb - 4'd1;
          if (r_nb == 4'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bip_uart_dbg.sv
// tb_bip_uart_dbg: host/BIP behavioural model driving bip_uart_dbg with directed and random commands
module tb_bip_uart_dbg;
  localparam int ACC_W = 16, PC_W = 11, CNT_W = 32, RST_CYC = 4, RUN_MAX = 12;
  logic clk = 0, reset = 1, rx_empty = 1, tx_full = 0;
  logic rd_uart, wr_uart, bip_en, bip_reset, bip_halt;
  logic [7:0] r_data = 0, w_data;
  logic [ACC_W-1:0] bip_acc = 0;
  logic [PC_W-1:0] bip_pc = 0;
  int en_tot = 0, rst_tot = 0, bad = 0, halt_lim = 1 << 30;
  int n_chk = 0, n_fail = 0, tx_rd = 0;
  logic [7:0] txq[$];
  logic [63:0] exp_cyc;
  always #5 clk = ~clk;
  assign bip_halt = en_tot >= halt_lim;
  bip_uart_dbg #(.ACC_W(ACC_W), .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYC(RST_CYC), .RUN_MAX(RUN_MAX)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .bip_acc(bip_acc), .bip_pc(bip_pc),
    .bip_halt(bip_halt), .bip_en(bip_en), .bip_reset(bip_reset)
  );
  // The BIP halts once its enable budget is spent; the TX FIFO just records pushes.
  always @(posedge clk) begin
    if (wr_uart) txq.push_back(w_data);
    if ((wr_uart && tx_full) || (rd_uart && rx_empty) || (bip_en && bip_reset)) bad <= bad + 1;
    if (bip_en) en_tot <= en_tot + 1;
    if (bip_reset) rst_tot <= rst_tot + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic host(input logic [7:0] b);
    logic popped = 0;
    r_data = b;
    rx_empty = 0;
    for (int i = 0; i < 200 && !popped; i++) begin
      @(posedge clk);
      popped = rd_uart;
    end
    @(negedge clk);
    rx_empty = 1;
    chk("rx_pop", popped, 1);
  endtask
  task automatic wait_tx(input int nb);
    for (int i = 0; i < 3000 && txq.size() - tx_rd < nb; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask
  task automatic expect_tx(input string tag, input logic [63:0] v, input int nb);
    chk({tag, "_len"}, txq.size() - tx_rd, nb);
    for (int i = 0; i < nb; i++)
      chk(tag, (tx_rd + i < txq.size()) ? {56'd0, txq[tx_rd + i]} : 'x, {56'd0, v[8*i +: 8]});
    tx_rd = txq.size();
  endtask
  task automatic cmd(input logic [7:0] c, input string tag, input logic [63:0] v, input int nb);
    host(c);
    wait_tx(nb);
    expect_tx(tag, v, nb);
  endtask
  initial begin
    int e0, d;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    chk("reset_out", {rd_uart, wr_uart, bip_en, bip_reset, w_data}, 0);
    reset = 0;
    @(negedge clk);
    chk("idle_out", {rd_uart, wr_uart, bip_en, bip_reset, w_data}, 0);
    e0 = rst_tot;
    cmd(8'h52, "R", 8'h06, 1);
    chk("R_cycles", rst_tot - e0, RST_CYC);
    exp_cyc = 0;
    cmd(8'h43, "C_init", exp_cyc, 4);
    bip_acc = 16'h1234;
    bip_pc = 11'h5A3;
    cmd(8'h41, "A", 64'h1234, 2);
    cmd(8'h50, "P", 64'h5A3, 2);
    for (int i = 0; i < 4; i++) begin
      bip_acc = ACC_W'($urandom);
      bip_pc = PC_W'($urandom);
      cmd(8'h41, "A_rnd", {48'd0, bip_acc}, 2);
      cmd(8'h50, "P_rnd", {53'd0, bip_pc}, 2);
    end
    for (int i = 0; i < 3; i++) begin
      e0 = en_tot;
      cmd(8'h53, "S", 8'h06, 1);
      chk("S_en", en_tot - e0, 1);
      exp_cyc += 1;
    end
    cmd(8'h43, "C_step", exp_cyc, 4);
    halt_lim = en_tot + 10;
    e0 = en_tot;
    cmd(8'h47, "G_halt", 8'h06, 1);
    chk("G_halt_en", en_tot - e0, 10);
    exp_cyc += 10;
    cmd(8'h43, "C_run", exp_cyc, 4);
    e0 = en_tot;
    cmd(8'h47, "G_halted", 8'h06, 1);
    cmd(8'h53, "S_halted", 8'h15, 1);
    chk("halted_en", en_tot - e0, 0);
    halt_lim = 1 << 30;
    e0 = en_tot;
    cmd(8'h47, "G_tmo", 8'h14, 1);
    chk("G_tmo_en", en_tot - e0, RUN_MAX);
    exp_cyc += RUN_MAX;
    e0 = en_tot;
    host(8'h47);
    repeat (3) @(negedge clk);
    host(8'h41);
    repeat (3) @(negedge clk);
    host(8'h1B);
    wait_tx(1);
    expect_tx("G_abort", 8'h18, 1);
    d = en_tot - e0;
    chk("abort_en_range", d > 0 && d < RUN_MAX, 1);
    exp_cyc += 64'(d);
    tx_full = 1;
    host(8'h43);
    repeat (20) @(negedge clk);
    chk("full_hold", txq.size() - tx_rd, 0);
    tx_full = 0;
    wait_tx(4);
    expect_tx("C_full", exp_cyc, 4);
    cmd(8'h7F, "NAK_7F", 8'h15, 1);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (b inside {8'h52, 8'h53, 8'h47, 8'h41, 8'h50, 8'h43}) b = 8'h00;
      cmd(b, "NAK_rnd", 8'h15, 1);
    end
    cmd(8'h52, "R2", 8'h06, 1);
    exp_cyc = 0;
    cmd(8'h43, "C_after_R", exp_cyc, 4);
    host(8'h47);
    repeat (3) @(negedge clk);
    chk("run_en", bip_en, 1);
    reset = 1;
    @(negedge clk);
    chk("reset_run_en", {bip_en, rd_uart, wr_uart}, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    chk("reset_idle", {bip_en, txq.size() - tx_rd}, 0);
    cmd(8'h43, "C_after_reset", 0, 4);
    chk("protocol", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
